// File: rtl/ft_rx_checker.sv
// Receive-side pattern checker for the FT600-style synchronous 245 FIFO link.
// Drains the bridge read FIFO with the OE_N/RD_N/RXF_N handshake and checks
// each word against the burst pattern: one header word, then BURST_SIZE
// payload words where payload word k is {k[DATA_W-1:1], 1'b1}.
//
// Handshake: a word moves on every rising edge where the registered read
// strobe (rdn) is low and the FIFO empty flag (rxfn) is low. Neither side may
// assume a transfer on any other edge. rdn only falls one cycle after oen, so
// the bus turnaround cycle is always honoured.
module ft_rx_checker #(
    parameter int DATA_W     = 8,
    parameter int BURST_SIZE = 256,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxfn,
    input  logic [DATA_W-1:0] data,
    output logic              oen,
    output logic              rdn,
    output logic              locked,
    output logic              burst_done,
    output logic              burst_ok,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        dbg_state
);

    localparam int POS_W = $clog2(BURST_SIZE + 1);
    localparam int KW    = (POS_W > DATA_W) ? POS_W : DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OE   = 2'd1,
        ST_READ = 2'd2
    } state_t;

    // Read FSM and its registered pin drivers
    state_t state_q, state_d;
    logic   oen_q, oen_d;
    logic   rdn_q, rdn_d;

    // Capture stage between the FIFO pins and the compare logic
    logic              cap_vld_q, cap_vld_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;

    // Parser / checker state
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [DATA_W-1:0] exp_hdr_q, exp_hdr_d;
    logic              bad_q, bad_d;
    logic              locked_q, locked_d;
    logic              burst_done_q, burst_done_d;
    logic              burst_ok_q, burst_ok_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    // Payload index arithmetic; only some bits feed the compare
    logic [KW-1:0]     k_ext;
    logic [DATA_W-1:0] pay_exp;
    logic              unused_k;

    // Headers count 1..max and skip zero on wrap
    function automatic logic [DATA_W-1:0] hdr_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? DATA_W'(1) : v + DATA_W'(1);
    endfunction

    // Next-state and pin-driver decode for the read handshake
    always_comb begin
        state_d = state_q;
        oen_d   = 1'b1;
        rdn_d   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!rxfn) begin
                    state_d = ST_OE;
                    oen_d   = 1'b0;
                end
            end
            ST_OE: begin
                if (rxfn) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                    oen_d   = 1'b0;
                    rdn_d   = 1'b0;
                end
            end
            ST_READ: begin
                if (rxfn) begin
                    state_d = ST_IDLE;
                end else begin
                    oen_d = 1'b0;
                    rdn_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture a word whenever the strobe is low and the FIFO is not empty
    always_comb begin
        cap_vld_d  = !rdn_q && !rxfn;
        cap_data_d = cap_vld_d ? data : cap_data_q;
    end

    // Expected payload word for the current parser position
    always_comb begin
        k_ext   = KW'(pos_q) - KW'(1);
        pay_exp = {k_ext[DATA_W-1:1], 1'b1};
    end

    assign unused_k = ^k_ext;

    // Header/payload compare, burst bookkeeping and counters
    always_comb begin
        logic err_hit;
        logic pay_mis;
        err_hit      = 1'b0;
        pay_mis      = 1'b0;
        pos_d        = pos_q;
        exp_hdr_d    = exp_hdr_q;
        bad_d        = bad_q;
        locked_d     = locked_q;
        burst_done_d = 1'b0;
        burst_ok_d   = burst_ok_q;
        burst_cnt_d  = burst_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (cap_vld_q) begin
            if (pos_q == '0) begin
                if (!locked_q) begin
                    // Any nonzero word is taken as the first header
                    if (cap_data_q != '0) begin
                        locked_d  = 1'b1;
                        exp_hdr_d = hdr_inc(cap_data_q);
                        pos_d     = POS_W'(1);
                    end else begin
                        err_hit = 1'b1;
                    end
                end else begin
                    if (cap_data_q != exp_hdr_q) begin
                        err_hit = 1'b1;
                        bad_d   = 1'b1;
                    end
                    // Resync to a nonzero header; a zero header just advances
                    exp_hdr_d = hdr_inc((cap_data_q != '0) ? cap_data_q : exp_hdr_q);
                    pos_d     = POS_W'(1);
                end
            end else begin
                if (cap_data_q != pay_exp) begin
                    pay_mis = 1'b1;
                    err_hit = 1'b1;
                    bad_d   = 1'b1;
                end
                if (pos_q == POS_W'(BURST_SIZE)) begin
                    burst_done_d = 1'b1;
                    burst_ok_d   = !(bad_q || pay_mis);
                    burst_cnt_d  = burst_cnt_q + CNT_W'(1);
                    pos_d        = '0;
                    bad_d        = 1'b0;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
        end
        if (err_hit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // All state registers; reset clears everything asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            oen_q        <= 1'b1;
            rdn_q        <= 1'b1;
            cap_vld_q    <= 1'b0;
            cap_data_q   <= '0;
            pos_q        <= '0;
            exp_hdr_q    <= '0;
            bad_q        <= 1'b0;
            locked_q     <= 1'b0;
            burst_done_q <= 1'b0;
            burst_ok_q   <= 1'b0;
            burst_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            oen_q        <= oen_d;
            rdn_q        <= rdn_d;
            cap_vld_q    <= cap_vld_d;
            cap_data_q   <= cap_data_d;
            pos_q        <= pos_d;
            exp_hdr_q    <= exp_hdr_d;
            bad_q        <= bad_d;
            locked_q     <= locked_d;
            burst_done_q <= burst_done_d;
            burst_ok_q   <= burst_ok_d;
            burst_cnt_q  <= burst_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign oen        = oen_q;
    assign rdn        = rdn_q;
    assign locked     = locked_q;
    assign burst_done = burst_done_q;
    assign burst_ok   = burst_ok_q;
    assign burst_cnt  = burst_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign dbg_state  = state_q;

endmodule
